// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit -- instruction-fetch stage of the Riscv151 pipeline.
//
// Owns the PC and issues one request at a time to the instruction cache. The
// fetched word and its PC are held in a single-entry registered buffer for the
// decode stage. A redirect from the X stage takes priority over everything
// else. If a request is still in flight when a redirect arrives, its response
// is squashed when it returns.
//
// Ports:
//   clk            pipeline clock, rising edge
//   reset          asynchronous, active-low reset
//   stall          downstream hold; the held instruction is not consumed
//   redirect_valid taken branch/jump from the X stage
//   redirect_pc    new fetch target (bits [1:0] ignored)
//   icache_re      request valid (combinational; depends on stall/redirect)
//   icache_addr    request address (always word aligned)
//   icache_ready   cache accepts the request this cycle
//   icache_valid   response valid, one per accepted request, in order
//   icache_dout    response instruction word
//   inst           instruction to decode (NOP_INST when inst_valid=0)
//   inst_pc        PC of inst (holds its last value while invalid)
//   inst_valid     inst is real and not squashed
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_2000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        icache_re,
  output logic [31:0] icache_addr,
  input  logic        icache_ready,
  input  logic        icache_valid,
  input  logic [31:0] icache_dout,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_valid
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t      state_r, state_s;
  logic [31:0] pc_r, pc_s;
  logic        squash_r, squash_s;
  logic [31:0] inst_r, inst_s;
  logic [31:0] inst_pc_r, inst_pc_s;
  logic        inst_valid_r, inst_valid_s;

  logic        consume_s;
  logic        redirect_s;
  logic        issue_s;
  logic [31:0] redirect_tgt_s;

  // Clears the byte-offset bits so every fetch address is word aligned.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

  // Request decision: the buffer must be free by the next edge, and a
  // redirect blocks the request so no wrong-path fetch is ever accepted.
  always_comb begin
    redirect_s     = redirect_valid && (state_r != BOOT);
    consume_s      = inst_valid_r && !stall;
    redirect_tgt_s = align_word(redirect_pc);
    issue_s        = (state_r == ISSUE) && (!inst_valid_r || consume_s) && !redirect_s;
  end

  // Next-state logic for the FSM, PC, squash flag and the output buffer.
  always_comb begin
    state_s      = state_r;
    pc_s         = pc_r;
    squash_s     = squash_r;
    inst_s       = inst_r;
    inst_pc_s    = inst_pc_r;
    inst_valid_s = inst_valid_r;

    if (redirect_s) begin
      pc_s         = redirect_tgt_s;
      inst_valid_s = 1'b0;
      inst_s       = NOP_INST;
      if ((state_r == WAIT) && !icache_valid) begin
        // Request still in flight: remember to drop its response.
        state_s  = WAIT;
        squash_s = 1'b1;
      end else begin
        // Either nothing outstanding or the response arrives right now and
        // is discarded on the spot.
        state_s  = ISSUE;
        squash_s = 1'b0;
      end
    end else begin
      if (consume_s) begin
        inst_valid_s = 1'b0;
        inst_s       = NOP_INST;
      end else begin
        inst_valid_s = inst_valid_r;
      end

      case (state_r)
        BOOT: begin
          // Any response seen here belongs to a pre-reset request.
          state_s = ISSUE;
        end
        ISSUE: begin
          if (issue_s && icache_ready) begin
            state_s = WAIT;
          end else begin
            state_s = ISSUE;
          end
        end
        WAIT: begin
          if (icache_valid) begin
            state_s = ISSUE;
            if (squash_r) begin
              // pc already holds the redirect target.
              squash_s = 1'b0;
            end else begin
              inst_s       = icache_dout;
              inst_pc_s    = pc_r;
              inst_valid_s = 1'b1;
              pc_s         = pc_r + 32'd4;
            end
          end else begin
            state_s = WAIT;
          end
        end
        default: begin
          state_s = BOOT;
        end
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= BOOT;
      pc_r         <= RESET_PC;
      squash_r     <= 1'b0;
      inst_r       <= NOP_INST;
      inst_pc_r    <= 32'h0000_0000;
      inst_valid_r <= 1'b0;
    end else begin
      state_r      <= state_s;
      pc_r         <= pc_s;
      squash_r     <= squash_s;
      inst_r       <= inst_s;
      inst_pc_r    <= inst_pc_s;
      inst_valid_r <= inst_valid_s;
    end
  end

  assign icache_re   = issue_s;
  assign icache_addr = pc_r;
  assign inst        = inst_r;
  assign inst_pc     = inst_pc_r;
  assign inst_valid  = inst_valid_r;

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit -- self-checking bench for fetch_unit.
// A small instruction-cache model answers accepted requests after a
// per-request latency. Directed cycles come from a vector table. Multi-cycle
// corner cases are written out by hand. A randomized streaming phase checks
// delivered instructions against a scoreboard of expected {pc, inst} pairs.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        icache_re;
  logic [31:0] icache_addr;
  logic        icache_ready = 1'b0;
  logic        icache_valid = 1'b0;
  logic [31:0] icache_dout = 32'h0;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_valid;

  fetch_unit dut (
    .clk(clk), .reset(reset), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .icache_re(icache_re), .icache_addr(icache_addr), .icache_ready(icache_ready),
    .icache_valid(icache_valid), .icache_dout(icache_dout),
    .inst(inst), .inst_pc(inst_pc), .inst_valid(inst_valid)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  // cache model and scoreboard state
  bit          pend = 1'b0;
  int          cnt = 0;
  logic [31:0] resp_data = 32'h0;
  bit          sb_on = 1'b0;
  logic [63:0] sb_q[$];
  logic [31:0] exp_addr = 32'h0;

  // sampled outputs of the current cycle
  logic        s_re;
  logic [31:0] s_addr;
  logic        s_iv;
  logic [31:0] s_inst;
  logic [31:0] s_ipc;

  typedef struct packed {
    logic        st;
    logic        rv;
    logic [31:0] rpc;
    logic        rdy;
    logic [1:0]  lat;
    logic        re;
    logic [31:0] addr;
    logic        iv;
    logic [31:0] ins;
    logic [31:0] ipc;
  } vec_t;

  vec_t vecs [25];

  function automatic vec_t mk(input logic st, input logic rv, input logic [31:0] rpc,
                              input logic rdy, input logic [1:0] lat, input logic re,
                              input logic [31:0] addr, input logic iv,
                              input logic [31:0] ins, input logic [31:0] ipc);
    vec_t v;
    v.st = st; v.rv = rv; v.rpc = rpc; v.rdy = rdy; v.lat = lat;
    v.re = re; v.addr = addr; v.iv = iv; v.ins = ins; v.ipc = ipc;
    return v;
  endfunction

  // cache contents: fixed words at the test-plan addresses, a pattern elsewhere
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_2000) return 32'h0050_0093;
    else if (a == 32'h0000_2008) return 32'hDEAD_BEEF;
    else return {a[27:0], 4'h3};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic sample();
    s_re = icache_re; s_addr = icache_addr; s_iv = inst_valid;
    s_inst = inst; s_ipc = inst_pc;
  endtask

  // One clock cycle: drive inputs, sample, model the cache, then advance
  // to one time unit past the next rising edge.
  task automatic run_cycle(input logic st, input logic rv, input logic [31:0] rpc,
                           input logic rdy, input int lat);
    logic        resp_now;
    logic [63:0] e;
    stall = st; redirect_valid = rv; redirect_pc = rpc; icache_ready = rdy;
    resp_now = pend && (cnt == 0);
    icache_valid = resp_now;
    icache_dout = resp_now ? resp_data : 32'h0;
    #1;
    sample();
    if (sb_on && s_iv && !st && !rv) begin
      if (sb_q.size() == 0) begin
        n_total++;
        $display("FAIL sb_underflow: got inst %h at pc %h, expected no instruction", s_inst, s_ipc);
      end else begin
        e = sb_q.pop_front();
        check("sb_inst", s_inst, e[31:0]);
        check("sb_pc", s_ipc, e[63:32]);
      end
    end
    if (s_re && rdy) begin
      check("one_outstanding", {31'b0, pend}, 32'h0);
      if (sb_on) begin
        check("sb_req_addr", s_addr, exp_addr);
        sb_q.push_back({exp_addr, mem_word(exp_addr)});
        exp_addr = exp_addr + 32'd4;
      end
      resp_data = mem_word(s_addr);
    end
    if (resp_now) pend = 1'b0;
    if (s_re && rdy) begin
      pend = 1'b1;
      cnt = lat;
    end else if (pend && cnt > 0) begin
      cnt--;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic re, input logic [31:0] addr,
                         input logic iv, input logic [31:0] ins, input logic [31:0] ipc);
    check({tag, "_re"}, {31'b0, s_re}, {31'b0, re});
    check({tag, "_addr"}, s_addr, addr);
    check({tag, "_iv"}, {31'b0, s_iv}, {31'b0, iv});
    check({tag, "_inst"}, s_inst, ins);
    check({tag, "_ipc"}, s_ipc, ipc);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, expected completion before 100000");
    $fatal(1);
  end

  initial begin
    // boot, stall hold, in-flight redirect, simultaneous redirect+response, wrap
    vecs[0]  = mk(0, 0, 32'h0,        1, 0, 0, 32'h2000,     0, NOP,          32'h0);
    vecs[1]  = mk(0, 0, 32'h0,        1, 0, 1, 32'h2000,     0, NOP,          32'h0);
    vecs[2]  = mk(0, 0, 32'h0,        1, 0, 0, 32'h2000,     0, NOP,          32'h0);
    vecs[3]  = mk(0, 0, 32'h0,        1, 0, 1, 32'h2004,     1, 32'h00500093, 32'h2000);
    vecs[4]  = mk(0, 0, 32'h0,        1, 0, 0, 32'h2004,     0, NOP,          32'h2000);
    for (int i = 5; i < 10; i++)
      vecs[i] = mk(1, 0, 32'h0,       1, 0, 0, 32'h2008,     1, 32'h00020043, 32'h2004);
    vecs[10] = mk(0, 0, 32'h0,        1, 1, 1, 32'h2008,     1, 32'h00020043, 32'h2004);
    vecs[11] = mk(0, 1, 32'h3002,     1, 0, 0, 32'h2008,     0, NOP,          32'h2004);
    vecs[12] = mk(0, 0, 32'h0,        1, 0, 0, 32'h3000,     0, NOP,          32'h2004);
    vecs[13] = mk(0, 0, 32'h0,        1, 0, 1, 32'h3000,     0, NOP,          32'h2004);
    vecs[14] = mk(0, 0, 32'h0,        1, 0, 0, 32'h3000,     0, NOP,          32'h2004);
    vecs[15] = mk(0, 0, 32'h0,        1, 0, 1, 32'h3004,     1, 32'h00030003, 32'h3000);
    vecs[16] = mk(0, 1, 32'h4000,     1, 0, 0, 32'h3004,     0, NOP,          32'h3000);
    vecs[17] = mk(0, 0, 32'h0,        1, 0, 1, 32'h4000,     0, NOP,          32'h3000);
    vecs[18] = mk(0, 0, 32'h0,        1, 0, 0, 32'h4000,     0, NOP,          32'h3000);
    vecs[19] = mk(1, 0, 32'h0,        1, 0, 0, 32'h4004,     1, 32'h00040003, 32'h4000);
    vecs[20] = mk(0, 1, 32'hFFFFFFFC, 1, 0, 0, 32'h4004,     1, 32'h00040003, 32'h4000);
    vecs[21] = mk(0, 0, 32'h0,        1, 0, 1, 32'hFFFFFFFC, 0, NOP,          32'h4000);
    vecs[22] = mk(0, 0, 32'h0,        1, 0, 0, 32'hFFFFFFFC, 0, NOP,          32'h4000);
    vecs[23] = mk(0, 0, 32'h0,        1, 2, 1, 32'h0,        1, 32'hFFFFFFC3, 32'hFFFFFFFC);
    vecs[24] = mk(0, 0, 32'h0,        1, 0, 0, 32'h0,        0, NOP,          32'hFFFFFFFC);

    // reset state
    icache_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    sample();
    chk_out("reset", 1'b0, 32'h2000, 1'b0, NOP, 32'h0);
    reset = 1'b1;

    for (int i = 0; i < 25; i++) begin
      run_cycle(vecs[i].st, vecs[i].rv, vecs[i].rpc, vecs[i].rdy, int'(vecs[i].lat));
      chk_out($sformatf("v%0d", i), vecs[i].re, vecs[i].addr, vecs[i].iv, vecs[i].ins, vecs[i].ipc);
    end

    // mid-op reset while a request is outstanding (WAIT)
    reset = 1'b0;
    #1;
    sample();
    chk_out("midrst", 1'b0, 32'h2000, 1'b0, NOP, 32'h0);
    run_cycle(0, 0, 32'h0, 1, 0);
    chk_out("midrst_hold", 1'b0, 32'h2000, 1'b0, NOP, 32'h0);
    reset = 1'b1;
    // stale response lands in BOOT and must be ignored
    run_cycle(0, 0, 32'h0, 1, 0);
    chk_out("boot_stale", 1'b0, 32'h2000, 1'b0, NOP, 32'h0);
    run_cycle(0, 0, 32'h0, 1, 0);
    chk_out("restart_req", 1'b1, 32'h2000, 1'b0, NOP, 32'h0);
    run_cycle(0, 0, 32'h0, 1, 0);
    chk_out("restart_wait", 1'b0, 32'h2000, 1'b0, NOP, 32'h0);

    // cache backpressure: three refused cycles, then exactly one instruction
    run_cycle(0, 0, 32'h0, 0, 0);
    chk_out("bp0", 1'b1, 32'h2004, 1'b1, 32'h00500093, 32'h2000);
    run_cycle(0, 0, 32'h0, 0, 0);
    chk_out("bp1", 1'b1, 32'h2004, 1'b0, NOP, 32'h2000);
    run_cycle(0, 0, 32'h0, 0, 0);
    chk_out("bp2", 1'b1, 32'h2004, 1'b0, NOP, 32'h2000);
    run_cycle(0, 0, 32'h0, 1, 0);
    chk_out("bp3", 1'b1, 32'h2004, 1'b0, NOP, 32'h2000);
    run_cycle(0, 0, 32'h0, 0, 0);
    chk_out("bp4", 1'b0, 32'h2004, 1'b0, NOP, 32'h2000);
    run_cycle(0, 0, 32'h0, 0, 0);
    chk_out("bp5", 1'b1, 32'h2008, 1'b1, 32'h00020043, 32'h2004);
    run_cycle(0, 0, 32'h0, 0, 0);
    chk_out("bp6", 1'b1, 32'h2008, 1'b0, NOP, 32'h2004);

    // randomized streaming against the scoreboard
    sb_on = 1'b1;
    exp_addr = 32'h2008;
    for (int i = 0; i < 300; i++)
      run_cycle(logic'($urandom_range(0, 3) == 0), 1'b0, 32'h0,
                logic'($urandom_range(0, 2) != 0), int'($urandom_range(0, 2)));
    for (int i = 0; i < 20 && sb_q.size() != 0; i++)
      run_cycle(0, 0, 32'h0, 0, 0);
    check("sb_drained", 32'(sb_q.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
